// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file scoreboard.
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_W = 32;
  localparam int unsigned REGFILE_DEPTH  = 32;
  localparam int unsigned REGFILE_NUM_RD = 2;
  localparam int unsigned REGFILE_ADDR_W = $clog2(REGFILE_DEPTH);

  typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array/busy lookup plus optional writeback bypass.
// Bypass is built when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REGFILE_DATA_W,
  parameter int unsigned DEPTH  = REGFILE_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DEPTH*DATA_W-1:0] mem,
  input  logic [DEPTH-1:0]        busy_vec,
`ifdef REGFILE_BYPASS_EN
  input  logic                    byp_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
`endif
  output logic [DATA_W-1:0]       data,
  output logic                    busy
);

  logic [DATA_W-1:0] entries [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
    assign entries[i] = mem[i*DATA_W +: DATA_W];
  end

  always_comb begin
    data = entries[addr];
    busy = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
    // byp_en already excludes register 0 and reset
    if (byp_en && (addr == wr_addr)) begin
      data = wr_data;
      busy = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, NUM_RD read ports and sticky error.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REGFILE_DATA_W,
  parameter int unsigned DEPTH  = REGFILE_DEPTH,
  parameter int unsigned NUM_RD = REGFILE_NUM_RD,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic                     err
);

  logic [DEPTH*DATA_W-1:0] mem_flat;
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    wr_hit;

  assign wr_hit = wr_en & (wr_addr != '0);

  // A writeback to the same register frees it in time for this reservation
  assign rsv_ok = rsv_en & ((rsv_addr == '0) | ~busy_q[rsv_addr]
                            | (wr_en & (wr_addr == rsv_addr)));

  always_comb begin
    busy_d = busy_q;
    if (wr_hit) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_ok && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign err_d = err_q | (wr_hit & ~busy_q[wr_addr]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    if (i == 0) begin : g_zero
      assign mem_flat[0 +: DATA_W] = '0;
    end else begin : g_entry
      logic [DATA_W-1:0] entry_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry_q <= '0;
        end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
          entry_q <= wr_data;
        end
      end

      assign mem_flat[i*DATA_W +: DATA_W] = entry_q;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_en;
  // Gated by rst so reads stay zero while reset is held
  assign byp_en = wr_hit & rst;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_read_port (
      .addr     (rd_addr[k*ADDR_W +: ADDR_W]),
      .mem      (mem_flat),
      .busy_vec (busy_q),
`ifdef REGFILE_BYPASS_EN
      .byp_en   (byp_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
`endif
      .data     (rd_data[k*DATA_W +: DATA_W]),
      .busy     (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int unsigned DW = REGFILE_DATA_W;
  localparam int unsigned NR = REGFILE_NUM_RD;
  localparam int unsigned AW = REGFILE_ADDR_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             rsv_ok;
  logic             err;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  regfile_scoreboard #(
    .DATA_W (DW),
    .DEPTH  (REGFILE_DEPTH),
    .NUM_RD (NR),
    .ADDR_W (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input reg_addr_t a0, input reg_addr_t a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  function automatic logic [31:0] port_data(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  initial begin
    rst      = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    #3;
    set_rd(5'd5, 5'd31);
    check("rst_data0", port_data(0), 32'h0);
    check("rst_busy", 32'(rd_busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    #3 rst = 1'b1;
    tick();

    // Idle after reset release
    check("idle_data0", port_data(0), 32'h0);
    check("idle_data1", port_data(1), 32'h0);
    check("idle_busy", 32'(rd_busy), 32'h0);
    check("idle_err", 32'(err), 32'h0);
    check("idle_rsv_ok", 32'(rsv_ok), 32'h0);

    // Reserve r5
    rsv_en = 1'b1; rsv_addr = 5'd5; #1;
    check("rsv5_ok", 32'(rsv_ok), 32'h1);
    tick();
    set_rd(5'd5, 5'd0);
    check("rsv5_busy", 32'(rd_busy[0]), 32'h1);
    check("rsv5_again_ok", 32'(rsv_ok), 32'h0);
    tick();
    rsv_en = 1'b0; #1;
    check("rsv5_still_busy", 32'(rd_busy[0]), 32'h1);

    // Write r5 while port1 reads it
    set_rd(5'd0, 5'd5);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; #1;
`ifdef REGFILE_BYPASS_EN
    check("wr5_same_data", port_data(1), 32'hDEADBEEF);
    check("wr5_same_busy", 32'(rd_busy[1]), 32'h0);
`else
    check("wr5_same_data", port_data(1), 32'h0);
    check("wr5_same_busy", 32'(rd_busy[1]), 32'h1);
`endif
    tick();
    wr_en = 1'b0; #1;
    check("wr5_next_data", port_data(1), 32'hDEADBEEF);
    check("wr5_next_busy", 32'(rd_busy[1]), 32'h0);
    check("wr5_err", 32'(err), 32'h0);
    set_rd(5'd5, 5'd5);
    check("dual_port0", port_data(0), 32'hDEADBEEF);
    check("dual_port1", port_data(1), 32'hDEADBEEF);

    // Reserve r7, then reserve again together with its writeback
    rsv_en = 1'b1; rsv_addr = 5'd7; #1;
    tick();
    #1;
    check("rsv7_busy_reject", 32'(rsv_ok), 32'h0);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12; #1;
    check("rsv7_wr_ok", 32'(rsv_ok), 32'h1);
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    set_rd(5'd7, 5'd0);
    check("r7_data", port_data(0), 32'h12);
    check("r7_busy", 32'(rd_busy[0]), 32'h1);
    check("r7_err", 32'(err), 32'h0);

    // Write to r0 is ignored
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    tick();
    wr_en = 1'b0;
    set_rd(5'd0, 5'd0);
    check("r0_data", port_data(0), 32'h0);
    check("r0_busy", 32'(rd_busy[0]), 32'h0);
    check("r0_err", 32'(err), 32'h0);

    // Write to non-reserved r3 raises sticky err
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick();
    wr_en = 1'b0;
    set_rd(5'd3, 5'd0);
    check("r3_err", 32'(err), 32'h1);
    check("r3_data", port_data(0), 32'h33);
    tick();
    tick();
    check("r3_err_sticky", 32'(err), 32'h1);

    // Reserve r9, then asynchronous reset mid-cycle
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    rsv_en = 1'b0;
    set_rd(5'd9, 5'd5);
    check("r9_busy", 32'(rd_busy[0]), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("arst_busy", 32'(rd_busy), 32'h0);
    check("arst_data5", port_data(1), 32'h0);
    check("arst_err", 32'(err), 32'h0);
    rsv_en = 1'b1; rsv_addr = 5'd9; #1;
    check("arst_rsv_ok", 32'(rsv_ok), 32'h1);
    rsv_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_busy", 32'(rd_busy[0]), 32'h0);
    check("post_rst_err", 32'(err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
